// File: rtl/fetch_mem_if.sv
// Instruction memory port between the fetch sequencer (master) and a
// combinational-read instruction memory (slave).
interface fetch_mem_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              cs;
  logic [15:0]       write_data;
  logic [15:0]       read_data;

  modport master (
    output address, read, write, cs, write_data,
    input  read_data
  );

  modport slave (
    input  address, read, write, cs, write_data,
    output read_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, sequences boot, one/two-word fetch,
// stall, branch redirect and interrupt vector entry, and registers the bundle.
module fetch_sequencer #(
  parameter int                ADDR_W           = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR   = '0,
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR     = ADDR_W'(1),
  parameter bit                USE_RESET_VECTOR = 1'b1,
  parameter logic [ADDR_W-1:0] RESET_PC         = ADDR_W'(32),
  parameter logic [4:0]        IMM_OP_A         = 5'b11010,
  parameter logic [4:0]        IMM_OP_B         = 5'b11011
) (
  input  logic              clk,
  input  logic              rst,
  fetch_mem_if.master       mem,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              int_req,
  output logic              int_ack,
  output logic [ADDR_W-1:0] epc_out,
  output logic [15:0]       instr_out,
  output logic [15:0]       imm_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out
);

  typedef enum logic [1:0] {BOOT, RUN, IMM, INTV} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       hold_instr;
  logic [ADDR_W-1:0] hold_pc;
  logic [4:0]        opcode;
  logic              is_two_word;

  assign opcode      = mem.read_data[15:11];
  assign is_two_word = (opcode == IMM_OP_A) || (opcode == IMM_OP_B);

  assign mem.cs         = ~rst;
  assign mem.read       = ~rst;
  assign mem.write      = 1'b0;
  assign mem.write_data = 16'h0000;

  always_comb begin
    mem.address = pc;
    case (state)
      BOOT:    mem.address = RESET_VEC_ADDR;
      INTV:    mem.address = INT_VEC_ADDR;
      default: mem.address = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= '0;
      instr_out  <= '0;
      imm_out    <= '0;
      pc_out     <= '0;
      valid_out  <= 1'b0;
      int_ack    <= 1'b0;
      epc_out    <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      case (state)
        BOOT: begin
          pc        <= USE_RESET_VECTOR ? ADDR_W'(mem.read_data) : RESET_PC;
          valid_out <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          // Interrupts are only taken here, i.e. on an instruction boundary.
          if (branch_taken) begin
            pc        <= branch_target;
            valid_out <= 1'b0;
          end else if (stall) begin
            state <= RUN;
          end else if (int_req) begin
            epc_out   <= pc;
            int_ack   <= 1'b1;
            valid_out <= 1'b0;
            state     <= INTV;
          end else if (is_two_word) begin
            hold_instr <= mem.read_data;
            hold_pc    <= pc;
            pc         <= pc + ADDR_W'(1);
            valid_out  <= 1'b0;
            state      <= IMM;
          end else begin
            instr_out <= mem.read_data;
            imm_out   <= 16'h0000;
            pc_out    <= pc;
            valid_out <= 1'b1;
            pc        <= pc + ADDR_W'(1);
          end
        end
        IMM: begin
          if (branch_taken) begin
            pc        <= branch_target;
            valid_out <= 1'b0;
            state     <= RUN;
          end else if (!stall) begin
            instr_out <= hold_instr;
            imm_out   <= mem.read_data;
            pc_out    <= hold_pc;
            valid_out <= 1'b1;
            pc        <= pc + ADDR_W'(1);
            state     <= RUN;
          end
        end
        INTV: begin
          pc        <= ADDR_W'(mem.read_data);
          int_ack   <= 1'b0;
          valid_out <= 1'b0;
          state     <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot, one/two-word fetch, stall,
// branch, interrupt entry, reset mid two-word fetch and PC wrap.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        int_req;
  logic        int_ack;
  logic [31:0] epc_out;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic [31:0] pc_out;
  logic        valid_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:255];

  fetch_mem_if #(.ADDR_W(32)) mem_if ();

  // Memory is combinational; anything above 0xFF reads as a NOP.
  assign mem_if.read_data = (mem_if.address[31:8] == 24'h0) ? mem[mem_if.address[7:0]] : 16'h0000;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (mem_if.master),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .int_req       (int_req),
    .int_ack       (int_ack),
    .epc_out       (epc_out),
    .instr_out     (instr_out),
    .imm_out       (imm_out),
    .pc_out        (pc_out),
    .valid_out     (valid_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_bundle(input string tag, input logic v, input logic [15:0] ins,
                              input logic [15:0] imm, input logic [31:0] pc);
    check_output({tag, "_valid"}, {31'h0, valid_out}, {31'h0, v});
    check_output({tag, "_instr"}, {16'h0, instr_out}, {16'h0, ins});
    check_output({tag, "_imm"},   {16'h0, imm_out},   {16'h0, imm});
    check_output({tag, "_pc"},    pc_out, pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0020;
    mem[8'h01] = 16'h0100;
    mem[8'h20] = 16'h0000;
    mem[8'h21] = 16'hD020;
    mem[8'h22] = 16'h0005;
    mem[8'h23] = 16'h9A20;
    mem[8'h24] = 16'h1111;
    mem[8'h25] = 16'hD800;
    mem[8'h26] = 16'h0077;
    mem[8'h27] = 16'h2222;
    mem[8'h28] = 16'hD020;
    mem[8'h29] = 16'h0009;
    mem[8'h40] = 16'h4040;
    mem[8'h41] = 16'h4141;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; int_req = 1'b0;
    step();
    step();
    $display("[TB] reset state");
    check_bundle("rst", 1'b0, 16'h0000, 16'h0000, 32'h0);
    check_output("rst_epc", epc_out, 32'h0);
    check_output("rst_ack", {31'h0, int_ack}, 32'h0);
    check_output("rst_cs", {31'h0, mem_if.cs}, 32'h0);
    check_output("rst_read", {31'h0, mem_if.read}, 32'h0);
    check_output("write_const", {15'h0, mem_if.write, mem_if.write_data}, 32'h0);

    rst = 1'b0;
    #1;
    check_output("boot_addr", mem_if.address, 32'h0);
    check_output("boot_cs", {30'h0, mem_if.cs, mem_if.read}, 32'h3);

    step();
    check_output("run_addr", mem_if.address, 32'h20);
    check_output("run_valid0", {31'h0, valid_out}, 32'h0);
    step();
    check_bundle("nop", 1'b1, 16'h0000, 16'h0000, 32'h20);
    check_output("nop_addr", mem_if.address, 32'h21);

    $display("[TB] two-word fetch");
    step();
    check_output("imm_gap_valid", {31'h0, valid_out}, 32'h0);
    check_output("imm_gap_addr", mem_if.address, 32'h22);
    step();
    check_bundle("ldm", 1'b1, 16'hD020, 16'h0005, 32'h21);
    step();
    check_bundle("after_ldm", 1'b1, 16'h9A20, 16'h0000, 32'h23);
    check_output("after_ldm_addr", mem_if.address, 32'h24);

    $display("[TB] stall three cycles");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bundle("stall", 1'b1, 16'h9A20, 16'h0000, 32'h23);
      check_output("stall_addr", mem_if.address, 32'h24);
    end
    stall = 1'b0;
    step();
    check_bundle("resume", 1'b1, 16'h1111, 16'h0000, 32'h24);

    $display("[TB] interrupt deferred during IMM");
    step();
    check_output("opb_gap_valid", {31'h0, valid_out}, 32'h0);
    int_req = 1'b1;
    stall   = 1'b1;
    step();
    check_output("imm_stall_valid", {31'h0, valid_out}, 32'h0);
    check_output("imm_stall_addr", mem_if.address, 32'h26);
    check_output("imm_no_ack", {31'h0, int_ack}, 32'h0);
    stall = 1'b0;
    step();
    check_bundle("opb", 1'b1, 16'hD800, 16'h0077, 32'h25);
    check_output("opb_no_ack", {31'h0, int_ack}, 32'h0);
    step();
    check_output("int_ack", {31'h0, int_ack}, 32'h1);
    check_output("int_epc", epc_out, 32'h27);
    check_output("int_addr", mem_if.address, 32'h1);
    check_output("int_valid", {31'h0, valid_out}, 32'h0);
    int_req = 1'b0;
    step();
    check_output("int_ack_drop", {31'h0, int_ack}, 32'h0);
    check_output("isr_addr", mem_if.address, 32'h100);
    step();
    check_bundle("isr", 1'b1, 16'h0000, 16'h0000, 32'h100);

    $display("[TB] branch with stall in RUN");
    branch_taken = 1'b1; branch_target = 32'h28; stall = 1'b1;
    step();
    check_output("br_run_valid", {31'h0, valid_out}, 32'h0);
    check_output("br_run_addr", mem_if.address, 32'h28);
    branch_taken = 1'b0; stall = 1'b0;
    step();
    check_output("br_imm_enter", mem_if.address, 32'h29);

    $display("[TB] branch with stall in IMM");
    branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    step();
    check_output("br_imm_addr", mem_if.address, 32'h40);
    check_bundle("br_imm_flush", 1'b0, 16'h0000, 16'h0000, 32'h100);
    branch_taken = 1'b0; stall = 1'b0;
    step();
    check_bundle("target", 1'b1, 16'h4040, 16'h0000, 32'h40);

    $display("[TB] reset mid two-word fetch");
    branch_taken = 1'b1; branch_target = 32'h21;
    step();
    branch_taken = 1'b0;
    step();
    check_output("pre_rst_addr", mem_if.address, 32'h22);
    rst = 1'b1;
    step();
    check_bundle("mid_rst", 1'b0, 16'h0000, 16'h0000, 32'h0);
    rst = 1'b0;
    #1;
    check_output("reboot_addr", mem_if.address, 32'h0);
    step();
    check_output("reboot_run", mem_if.address, 32'h20);
    step();
    check_bundle("reboot_nop", 1'b1, 16'h0000, 16'h0000, 32'h20);

    $display("[TB] pc wrap");
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    check_output("wrap_addr", mem_if.address, 32'hFFFF_FFFF);
    step();
    check_bundle("wrap", 1'b1, 16'h0000, 16'h0000, 32'hFFFF_FFFF);
    check_output("wrap_next", mem_if.address, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
